aes_round_key_buffer: RTL and testbench
=======================================

# aes_round_key_buffer

Parametrised round-key store between the byte-serial key-expansion datapath and the encryption core. It captures every expanded round key once per key load, in beats of `DW` bytes, for AES-128/192/256 via `NR`. It then streams any requested round key to the consumer on a valid/ready handshake, so the encrypt path is no longer tied to free-running cycle counters. Key reload, read requests and errors are all explicit handshakes.

## Interface
- `DW`, 1, bytes per beat; legal values 1, 2, 4, 8, 16.
- `NR`, 10, number of AES rounds; legal values 10, 12, 14. The store holds `NR+1` round keys.
- Derived, not overridable:
  - `BPR` = 16/`DW`, beats per round key.
  - `TOTAL` = (`NR`+1)·`BPR`.
  - `RW` = clog2(`NR`+1).
- Reset `rst` is synchronous and active-high. Clock is `clk`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `kx_start` in 1: one-cycle pulse that begins a new key load and invalidates the stored keys.
- `kx_valid` in 1: expanded-key beat present.
- `kx_data` in 8·`DW`: expanded-key beat. The first byte is in the most significant lane.
- `kx_ready` out 1: buffer accepts a write beat.
- `key_ready` out 1: all `TOTAL` beats have been captured.
- `rd_req` in 1: request to stream round `rd_round`.
- `rd_round` in `RW`: requested round index, 0..`NR`.
- `rd_busy` out 1: a stream is in progress.
- `rd_err` out 1: one-cycle pulse when a request is rejected.
- `rk_valid` out 1: round-key beat valid.
- `rk_ready` in 1: consumer accepts the beat.
- `rk_data` out 8·`DW`: round-key beat.
- `rk_last` out 1: marks the final beat of a round key.

## Operation
- Storage is `TOTAL` entries of 8·`DW` bits.
- Round r, beat b lives at address r·`BPR`+b.
- Byte order: round-key bits [127:120] arrive first, both on the write side and on the read side.
- The write FSM has three states:
  - IDLE: after reset. `kx_ready`=0, `key_ready`=0.
  - LOAD: entered on `kx_start`. `kx_ready`=1. Each `kx_valid`&&`kx_ready` cycle writes at `wptr` and increments it. When the beat at `wptr`=`TOTAL`-1 is written, the FSM goes to READY.
  - READY: `kx_ready`=0, `key_ready`=1. Further `kx_valid` is ignored.
- `kx_start` in any state, including mid-LOAD or READY:
  - `wptr` returns to 0.
  - The FSM goes to LOAD.
  - `key_ready` drops on the next cycle.
  - Any active stream is aborted: `rk_valid`, `rk_last` and `rd_busy` are 0 on the next cycle.
- `kx_start` together with `kx_valid` in the same cycle: the start wins and that data beat is discarded.
- The read FSM has two states, RIDLE and STREAM.
- A request is accepted when all of the following hold: `rd_req`=1, `rd_busy`=0, `key_ready`=1, `rd_round`≤`NR`, and `kx_start`=0.
  - On acceptance, `rptr` = `rd_round`·`BPR`, `bcnt` = 0, and the FSM goes to STREAM.
- A request is rejected, with a single `rd_err` pulse on the next cycle and no stream, when:
  - `key_ready`=0, or
  - `rd_round`>`NR`.
- `rd_req` while `rd_busy`=1 is ignored silently, with no `rd_err`.
- In STREAM:
  - `rk_data` comes from the memory at `rptr`.
  - On `rk_valid`&&`rk_ready`, `rptr` and `bcnt` increment.
  - `rk_last` = `rk_valid` && (`bcnt`==`BPR`-1).
  - When the last beat is accepted, the FSM returns to RIDLE.
- Reads are non-destructive. Any round can be streamed any number of times until the next `kx_start`.

## Timing
- Reset values: `kx_ready`=0, `key_ready`=0, `rd_busy`=0, `rd_err`=0, `rk_valid`=0, `rk_last`=0, `rk_data`=0. Both FSMs reset to IDLE/RIDLE; `wptr`=0, `rptr`=0.
- Reset mid-load or mid-stream returns all of the above to their reset values on the next edge. Memory contents are don't-care after reset.
- Write side:
  - `kx_ready` is 1 in the cycle after `kx_start`.
  - Throughput is 1 beat/cycle.
  - `key_ready` rises 1 cycle after the final write beat.
- Read side:
  - A request accepted in cycle t gives `rk_valid`=1 and `rd_busy`=1 in cycle t+1 (registered read).
  - With `rk_ready` held at 1, the `BPR` beats appear on consecutive cycles.
  - `rd_busy` and `rk_valid` fall in the cycle after the last-beat handshake.
  - The next `rd_req` can be accepted in that same cycle, so the gap between streams is 1 idle cycle.
- Stall: while `rk_valid`=1 and `rk_ready`=0, `rk_data` and `rk_last` are held stable.
- `rd_err` lasts exactly 1 cycle per rejected request, presented the cycle after the request.

## Test plan
- Load test: `DW`=1, `NR`=10. Load the FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c expansion (176 beats).
  - `key_ready` rises 1 cycle after beat 175.
  - `rd_round`=1 streams a0,fa,fe,17,…,05 over 16 cycles, with `rk_last` on byte 05.
- `DW`=4, `NR`=10, same key. `rd_round`=10 gives 4 beats: d014f9a8, c9ee2589, e13f0cc8, b6630ca6. `rk_last` is on beat 4.
- Backpressure: `DW`=4. Drive `rk_ready` with the pattern 1,0,0,1,0,1,1. `rk_data` holds during stalls, every word is delivered once in order, and `rd_busy` falls after the 4th handshake.
- Errors:
  - `rd_req` before `key_ready` gives an `rd_err` pulse and `rk_valid` stays 0.
  - With `NR`=10, `rd_round`=11 gives an `rd_err` pulse.
  - `rd_req` during STREAM: no `rd_err`, and the stream is unchanged.
- Abort and reload: `kx_start` on beat 2 of a round-5 stream.
  - Next cycle: `rk_valid`=0, `rd_busy`=0, `key_ready`=0.
  - A new key 000102…0f is loaded; `rd_round`=0 returns 00,01,…,0f.
- Reset: `rst` mid-LOAD at beat 50.
  - All outputs return to their reset values.
  - A full load after `kx_start` completes correctly.

Source files
------------

// File: rtl/aes_round_key_buffer.sv
// Round-key store between key expansion and the cipher core: captures NR+1 round keys
// in DW-byte beats, then streams any requested round key on a valid/ready handshake.
module aes_round_key_buffer #(
    parameter int unsigned DW = 1,
    parameter int unsigned NR = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      kx_start,
    input  logic                      kx_valid,
    input  logic [8*DW-1:0]           kx_data,
    output logic                      kx_ready,
    output logic                      key_ready,
    input  logic                      rd_req,
    input  logic [$clog2(NR+1)-1:0]   rd_round,
    output logic                      rd_busy,
    output logic                      rd_err,
    output logic                      rk_valid,
    input  logic                      rk_ready,
    output logic [8*DW-1:0]           rk_data,
    output logic                      rk_last
);
    localparam int unsigned BPR   = 16 / DW;
    localparam int unsigned TOTAL = (NR + 1) * BPR;
    localparam int unsigned AW    = $clog2(TOTAL);
    localparam int unsigned BW    = $clog2(BPR + 1);
    localparam int unsigned DBW   = 8 * DW;

    typedef enum logic [1:0] {W_IDLE, W_LOAD, W_READY} wstate_t;
    typedef enum logic {R_IDLE, R_STREAM} rstate_t;

    wstate_t        wstate;
    rstate_t        rstate;
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [BW-1:0]  bcnt;
    logic [DBW-1:0] mem [TOTAL];

    logic           in_range;
    logic           accept;
    logic           reject;
    logic [AW-1:0]  base;

    assign in_range = (32'(rd_round) <= NR);
    assign accept   = rd_req && !rd_busy && key_ready && in_range && !kx_start;
    assign reject   = rd_req && !rd_busy && (!key_ready || !in_range);
    assign base     = AW'(32'(rd_round) * BPR);

    // Write side: kx_start always restarts the load, even mid-load or when ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate    <= W_IDLE;
            wptr      <= '0;
            kx_ready  <= 1'b0;
            key_ready <= 1'b0;
        end else if (kx_start) begin
            wstate    <= W_LOAD;
            wptr      <= '0;
            kx_ready  <= 1'b1;
            key_ready <= 1'b0;
        end else begin
            case (wstate)
                W_LOAD: begin
                    if (kx_valid) begin
                        if (wptr == AW'(TOTAL - 1)) begin
                            wstate    <= W_READY;
                            kx_ready  <= 1'b0;
                            key_ready <= 1'b1;
                        end else begin
                            wptr <= wptr + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Key storage carries no reset; a beat coinciding with kx_start is dropped.
    always_ff @(posedge clk) begin
        if (wstate == W_LOAD && kx_valid && !kx_start) begin
            mem[wptr] <= kx_data;
        end
    end

    // Read side: registered read, so the first beat appears the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate   <= R_IDLE;
            rptr     <= '0;
            bcnt     <= '0;
            rd_busy  <= 1'b0;
            rd_err   <= 1'b0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            rk_data  <= '0;
        end else begin
            rd_err <= reject;
            if (kx_start) begin
                rstate   <= R_IDLE;
                rd_busy  <= 1'b0;
                rk_valid <= 1'b0;
                rk_last  <= 1'b0;
            end else begin
                case (rstate)
                    R_IDLE: begin
                        if (accept) begin
                            rstate   <= R_STREAM;
                            rptr     <= base;
                            bcnt     <= '0;
                            rd_busy  <= 1'b1;
                            rk_valid <= 1'b1;
                            rk_last  <= (BPR == 1);
                            rk_data  <= mem[base];
                        end
                    end
                    R_STREAM: begin
                        if (rk_ready) begin
                            if (bcnt == BW'(BPR - 1)) begin
                                rstate   <= R_IDLE;
                                rd_busy  <= 1'b0;
                                rk_valid <= 1'b0;
                                rk_last  <= 1'b0;
                            end else begin
                                rptr    <= rptr + AW'(1);
                                bcnt    <= bcnt + BW'(1);
                                rk_data <= mem[rptr + AW'(1)];
                                rk_last <= (bcnt + BW'(1) == BW'(BPR - 1));
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_round_key_buffer.sv
// Self-checking bench for aes_round_key_buffer (DW=4, NR=10): AES-128 expansion model,
// directed known-answer, backpressure, error, abort and reset steps, then random loads/reads.
module tb_aes_round_key_buffer;
    localparam int unsigned DW = 4;
    localparam int unsigned NR = 10;
    localparam int NW = 44;

    logic        clk = 1'b0;
    logic        rst;
    logic        kx_start, kx_valid, kx_ready, key_ready;
    logic [31:0] kx_data;
    logic        rd_req, rd_busy, rd_err;
    logic [3:0]  rd_round;
    logic        rk_valid, rk_ready, rk_last;
    logic [31:0] rk_data;

    int checks = 0;
    int failures = 0;
    logic [31:0] kw [NW];

    aes_round_key_buffer #(.DW(DW), .NR(NR)) dut (
        .clk(clk), .rst(rst),
        .kx_start(kx_start), .kx_valid(kx_valid), .kx_data(kx_data), .kx_ready(kx_ready),
        .key_ready(key_ready),
        .rd_req(rd_req), .rd_round(rd_round), .rd_busy(rd_busy), .rd_err(rd_err),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_last(rk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // GF(2^8) arithmetic for the AES S-box and key schedule.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v = 8'h00;
        if (a != 8'h00) begin
            v = 8'h01;
            for (int i = 0; i < 254; i++) v = gmul(v, a);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [7:0]  rcon = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) kw[i] = key[127-32*i -: 32];
        for (int i = 4; i < NW; i++) begin
            t = kw[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            kw[i] = kw[i-4] ^ t;
        end
    endtask

    function automatic logic [127:0] rk_of(input int r);
        return {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
    endfunction

    task automatic check_reset_outputs();
        chk("rst_kx_ready", kx_ready, 0);
        chk("rst_key_ready", key_ready, 0);
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_rk_valid", rk_valid, 0);
        chk("rst_rk_last", rk_last, 0);
        chk("rst_rk_data", rk_data, 0);
    endtask

    // Load kw[] with gap percentage; rst_at >= 0 applies reset before that beat instead.
    task automatic load_key(input int gap, input int rst_at);
        int i = 0;
        kx_start = 1'b1; kx_valid = 1'b1; kx_data = 32'hdeadbeef;
        @(negedge clk);
        kx_start = 1'b0;
        chk("load_kx_ready", kx_ready, 1);
        chk("load_key_ready_low", key_ready, 0);
        while (i < NW) begin
            if (i == rst_at) begin
                kx_valid = 1'b0; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_outputs();
                return;
            end
            kx_valid = ($urandom_range(0, 99) >= 32'(gap));
            kx_data  = kx_valid ? kw[i] : $urandom;
            @(negedge clk);
            if (kx_valid) i++;
            if (i < NW) chk("key_ready_early", key_ready, 0);
        end
        kx_valid = 1'b1; kx_data = 32'hbad0bad0;
        chk("key_ready_rise", key_ready, 1);
        chk("kx_ready_fall", kx_ready, 0);
        @(negedge clk);
        kx_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: pattern 1,0,0,1,0,1,1.
    task automatic read_round(input int r, input int mode, input bit inject, input logic [127:0] expk);
        int b = 0;
        int cyc = 0;
        logic [6:0] pat = 7'b1001011;
        rd_req = 1'b1; rd_round = 4'(r);
        @(negedge clk);
        rd_req = 1'b0;
        chk("rd_busy_rise", rd_busy, 1);
        while (b < 4 && cyc < 64) begin
            rk_ready = (mode == 0) ? 1'b1 : (mode == 2) ? pat[6 - (cyc % 7)] : 1'($urandom_range(0, 1));
            rd_req   = inject && (b == 1);
            rd_round = 4'((r + 1) % 11);
            chk("rk_valid", rk_valid, 1);
            chk("rk_data", rk_data, expk[127-32*b -: 32]);
            chk("rk_last", rk_last, (b == 3));
            chk("rd_err_quiet", rd_err, 0);
            @(negedge clk);
            if (rk_ready) b++;
            cyc++;
        end
        rd_req = 1'b0; rk_ready = 1'b0;
        chk("stream_beats", b, 4);
        chk("rd_busy_fall", rd_busy, 0);
        chk("rk_valid_fall", rk_valid, 0);
        chk("rd_err_after", rd_err, 0);
    endtask

    task automatic req_err(input int r);
        rd_req = 1'b1; rd_round = 4'(r);
        @(negedge clk);
        rd_req = 1'b0;
        chk("rd_err_pulse", rd_err, 1);
        chk("rd_err_no_valid", rk_valid, 0);
        chk("rd_err_no_busy", rd_busy, 0);
        @(negedge clk);
        chk("rd_err_single", rd_err, 0);
        chk("rd_err_no_valid2", rk_valid, 0);
    endtask

    initial begin
        rst = 1'b1; kx_start = 1'b0; kx_valid = 1'b0; kx_data = '0;
        rd_req = 1'b0; rd_round = '0; rk_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        req_err(0);

        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        load_key(0, -1);
        read_round(1, 0, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605);
        read_round(10, 0, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_round(10, 2, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_round(3, 1, 1'b1, rk_of(3));
        read_round(0, 0, 1'b0, rk_of(0));
        req_err(11);
        req_err(15);

        // Abort a round-5 stream after two beats with kx_start.
        rd_req = 1'b1; rd_round = 4'd5;
        @(negedge clk);
        rd_req = 1'b0; rk_ready = 1'b1;
        chk("abort_beat0", rk_data, kw[20]);
        repeat (2) @(negedge clk);
        chk("abort_beat2", rk_data, kw[22]);
        kx_start = 1'b1;
        @(negedge clk);
        kx_start = 1'b0; rk_ready = 1'b0;
        chk("abort_rk_valid", rk_valid, 0);
        chk("abort_rd_busy", rd_busy, 0);
        chk("abort_rk_last", rk_last, 0);
        chk("abort_key_ready", key_ready, 0);
        chk("abort_kx_ready", kx_ready, 1);

        expand(128'h000102030405060708090a0b0c0d0e0f);
        load_key(30, -1);
        read_round(0, 0, 1'b0, 128'h000102030405060708090a0b0c0d0e0f);
        read_round(10, 1, 1'b0, rk_of(10));

        // Reset mid-load, then a clean load.
        load_key(0, 20);
        load_key(0, -1);
        read_round(7, 1, 1'b0, rk_of(7));

        // Reset mid-stream.
        rd_req = 1'b1; rd_round = 4'd2;
        @(negedge clk);
        rd_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NW; i++) kw[i] = $urandom;
            load_key(25, -1);
            for (int j = 0; j < 8; j++) begin
                int r;
                r = int'($urandom_range(0, 10));
                read_round(r, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rk_of(r));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
